// File: rtl/axis_serdes_tx.sv
// axis_serdes_tx: AXI4-Stream byte serializer with K28.5 framing and 8b/10b
// line coding; drives one bit per clock on strobout (symbol bit a first).
// Optional statistics counters are built only when AXIS_SERDES_TX_STATS_EN
// is defined; otherwise stat_bytes/stat_commas are tied to zero.
module axis_serdes_tx #(
  parameter int unsigned NUM_BYTES_PER_PACKET = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  output logic        strobout,
  output logic        sym_start,
  output logic [15:0] stat_bytes,
  output logic [15:0] stat_commas
);

  localparam int unsigned SLOT_W = (NUM_BYTES_PER_PACKET > 2) ? $clog2(NUM_BYTES_PER_PACKET) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_BYTES_PER_PACKET - 1);
  localparam logic [SLOT_W-1:0] SLOT_ONE  = SLOT_W'(1);
  localparam logic [3:0] BIT_LAST = 4'd9;
  // Symbols stored with bit 0 = a (first on the line), bit 9 = j.
  localparam logic [9:0] K28_5_RDN = 10'b0101111100;
  localparam logic [9:0] K28_5_RDP = 10'b1010000011;

  // 5b/6b sub-block, RD- form, written abcdei with a as MSB
  function automatic logic [5:0] enc6(input logic [4:0] x);
    logic [5:0] c;
    case (x)
      5'd0:  c = 6'b100111;  5'd1:  c = 6'b011101;
      5'd2:  c = 6'b101101;  5'd3:  c = 6'b110001;
      5'd4:  c = 6'b110101;  5'd5:  c = 6'b101001;
      5'd6:  c = 6'b011001;  5'd7:  c = 6'b111000;
      5'd8:  c = 6'b111001;  5'd9:  c = 6'b100101;
      5'd10: c = 6'b010101;  5'd11: c = 6'b110100;
      5'd12: c = 6'b001101;  5'd13: c = 6'b101100;
      5'd14: c = 6'b011100;  5'd15: c = 6'b010111;
      5'd16: c = 6'b011011;  5'd17: c = 6'b100011;
      5'd18: c = 6'b010011;  5'd19: c = 6'b110010;
      5'd20: c = 6'b001011;  5'd21: c = 6'b101010;
      5'd22: c = 6'b011010;  5'd23: c = 6'b111010;
      5'd24: c = 6'b110011;  5'd25: c = 6'b100110;
      5'd26: c = 6'b010110;  5'd27: c = 6'b110110;
      5'd28: c = 6'b001110;  5'd29: c = 6'b101110;
      5'd30: c = 6'b011110;  default: c = 6'b101011;
    endcase
    return c;
  endfunction

  // Full data-symbol encode: returns {rd_out, symbol[9:0]}
  function automatic logic [10:0] enc_data(input logic [7:0] d, input logic rd_in);
    logic [4:0] x;
    logic [2:0] y;
    logic [5:0] c6;
    logic [3:0] c4;
    logic       bal6;
    logic       bal4;
    logic       rd_mid;
    logic       rd_out;
    logic       alt7;
    x    = d[4:0];
    y    = d[7:5];
    c6   = enc6(x);
    bal6 = ($countones(c6) == 3);
    // Unbalanced codes and D.07 use the complemented form at RD+
    if (rd_in && (!bal6 || (x == 5'd7))) c6 = ~c6;
    rd_mid = bal6 ? rd_in : ~rd_in;
    // A7 replaces P7 where P7 would create a run of five
    alt7 = rd_mid ? ((x == 5'd11) || (x == 5'd13) || (x == 5'd14))
                  : ((x == 5'd17) || (x == 5'd18) || (x == 5'd20));
    case (y)
      3'd0:    c4 = 4'b1011;
      3'd1:    c4 = 4'b1001;
      3'd2:    c4 = 4'b0101;
      3'd3:    c4 = 4'b1100;
      3'd4:    c4 = 4'b1101;
      3'd5:    c4 = 4'b1010;
      3'd6:    c4 = 4'b0110;
      default: c4 = alt7 ? 4'b0111 : 4'b1110;
    endcase
    bal4 = ($countones(c4) == 2);
    if (rd_mid && (!bal4 || (y == 3'd3))) c4 = ~c4;
    rd_out = bal4 ? rd_mid : ~rd_mid;
    return {rd_out, c4[0], c4[1], c4[2], c4[3], c6[0], c6[1], c6[2], c6[3], c6[4], c6[5]};
  endfunction

  logic [3:0]        bit_cnt;
  logic [SLOT_W-1:0] slot;
  logic              rd;
  logic [9:0]        shreg;

  logic              load;
  logic              hs;
  logic              comma;
  logic [3:0]        bit_nxt;
  logic [10:0]       enc;
  logic [9:0]        sym_nxt;
  logic              rd_nxt;
  logic [SLOT_W-1:0] slot_nxt;

  // Next-symbol selection evaluated for the upcoming load edge
  always_comb begin
    load     = (bit_cnt == BIT_LAST);
    hs       = s_axis_tready && s_axis_tvalid;
    bit_nxt  = bit_cnt + 4'd1;
    enc      = enc_data(s_axis_tdata, rd);
    comma    = 1'b1;
    sym_nxt  = rd ? K28_5_RDP : K28_5_RDN;
    rd_nxt   = ~rd;
    slot_nxt = SLOT_ONE;
    if ((slot != '0) && hs) begin
      comma    = 1'b0;
      sym_nxt  = enc[9:0];
      rd_nxt   = enc[10];
      slot_nxt = (s_axis_tlast || (slot == SLOT_LAST)) ? '0 : slot + SLOT_ONE;
    end
  end

  // Bit counter, frame slot, disparity and registered line outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt       <= BIT_LAST;
      slot          <= '0;
      rd            <= 1'b0;
      shreg         <= '0;
      strobout      <= 1'b0;
      sym_start     <= 1'b0;
      s_axis_tready <= 1'b0;
    end else if (load) begin
      bit_cnt       <= 4'd0;
      slot          <= slot_nxt;
      rd            <= rd_nxt;
      shreg         <= sym_nxt;
      strobout      <= sym_nxt[0];
      sym_start     <= 1'b1;
      s_axis_tready <= 1'b0;
    end else begin
      bit_cnt       <= bit_nxt;
      strobout      <= shreg[bit_nxt];
      sym_start     <= 1'b0;
      s_axis_tready <= (bit_nxt == BIT_LAST) && (slot != '0);
    end
  end

`ifdef AXIS_SERDES_TX_STATS_EN
  // Wrapping counters of accepted bytes and emitted K28.5 symbols
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_bytes  <= 16'd0;
      stat_commas <= 16'd0;
    end else if (load) begin
      if (comma) stat_commas <= stat_commas + 16'd1;
      else       stat_bytes  <= stat_bytes + 16'd1;
    end
  end
`else
  assign stat_bytes  = 16'd0;
  assign stat_commas = 16'd0;
`endif

endmodule
